// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator flag decoder: condition-code
// encodings and the handshake FSM state encoding.
package cmp_pkg;

    // Condition codes carried on the cond input alongside the flag set
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_LT = 4'd2;
    localparam logic [3:0] COND_GE = 4'd3;
    localparam logic [3:0] COND_GT = 4'd4;
    localparam logic [3:0] COND_LE = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_MI = 4'd8;
    localparam logic [3:0] COND_PL = 4'd9;
    localparam logic [3:0] COND_LO = 4'd10;
    localparam logic [3:0] COND_HS = 4'd11;
    localparam logic [3:0] COND_HI = 4'd12;
    localparam logic [3:0] COND_LS = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // Handshake FSM states; encoding 2'd3 is unused and recovers to idle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/cmp_cond_eval.sv
// Combinational condition evaluator: maps a V/N/Z(/C) flag set and a 4-bit
// condition code onto a single result bit plus an error bit.
// Optional feature macro: CMP_UNSIGNED_EN (adds the carry input and enables
// the unsigned codes LO/HS/HI/LS; without it those codes report an error).
module cmp_cond_eval
    import cmp_pkg::*;
(
    input  logic       v,
    input  logic       n,
    input  logic       z,
`ifdef CMP_UNSIGNED_EN
    input  logic       c,
`endif
    input  logic [3:0] cond,
    output logic       result,
    output logic       err
);

    logic s_s;
    logic cond_err_s;

    // Signed less-than indicator derived from negative and overflow flags
    assign s_s = n ^ v;

    // Condition table lookup; Z and N both set is flagged as an impossible flag set
    always_comb begin
        result     = 1'b0;
        cond_err_s = 1'b0;
        case (cond)
            COND_EQ: result = z;
            COND_NE: result = ~z;
            COND_LT: result = s_s;
            COND_GE: result = ~s_s;
            COND_GT: result = ~z & ~s_s;
            COND_LE: result = z | s_s;
            COND_VS: result = v;
            COND_VC: result = ~v;
            COND_MI: result = n;
            COND_PL: result = ~n;
`ifdef CMP_UNSIGNED_EN
            COND_LO: result = ~c;
            COND_HS: result = c;
            COND_HI: result = c & ~z;
            COND_LS: result = ~c | z;
`else
            COND_LO, COND_HS, COND_HI, COND_LS: begin
                result     = 1'b0;
                cond_err_s = 1'b1;
            end
`endif
            COND_AL: result = 1'b1;
            COND_NV: result = 1'b0;
            default: begin
                result     = 1'b0;
                cond_err_s = 1'b1;
            end
        endcase
        err = (z & n) | cond_err_s;
    end

endmodule

// File: rtl/cmp_flag_decoder.sv
// Consumer side of the comparator flag interface. Captures a flag set and
// condition code, evaluates it one cycle later and presents the result over
// a valid/ready handshake. Also counts accepted overflow events (saturating).
// Optional feature macro: CMP_UNSIGNED_EN (adds the c_in carry port).
module cmp_flag_decoder
    import cmp_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_valid,
    output logic             flag_ready,
    input  logic             v_in,
    input  logic             n_in,
    input  logic             z_in,
`ifdef CMP_UNSIGNED_EN
    input  logic             c_in,
`endif
    input  logic [3:0]       cond,
    output logic             result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             flag_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_count
);

    state_e           state_r;
    logic             v_r;
    logic             n_r;
    logic             z_r;
`ifdef CMP_UNSIGNED_EN
    logic             c_r;
`endif
    logic [3:0]       cond_r;
    logic             result_r;
    logic             flag_err_r;
    logic             result_valid_r;
    logic             flag_ready_r;
    logic [CNT_W-1:0] ovf_count_r;
    logic             accept_s;
    logic             eval_result_s;
    logic             eval_err_s;

    // flag_ready_r is only high in idle, so it alone qualifies an accept
    assign accept_s = flag_valid & flag_ready_r;

    cmp_cond_eval u_cond_eval (
        .v      (v_r),
        .n      (n_r),
        .z      (z_r),
`ifdef CMP_UNSIGNED_EN
        .c      (c_r),
`endif
        .cond   (cond_r),
        .result (eval_result_s),
        .err    (eval_err_s)
    );

    // Handshake FSM with flag capture and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            v_r            <= 1'b0;
            n_r            <= 1'b0;
            z_r            <= 1'b0;
`ifdef CMP_UNSIGNED_EN
            c_r            <= 1'b0;
`endif
            cond_r         <= 4'd0;
            result_r       <= 1'b0;
            flag_err_r     <= 1'b0;
            result_valid_r <= 1'b0;
            flag_ready_r   <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        v_r          <= v_in;
                        n_r          <= n_in;
                        z_r          <= z_in;
`ifdef CMP_UNSIGNED_EN
                        c_r          <= c_in;
`endif
                        cond_r       <= cond;
                        flag_ready_r <= 1'b0;
                        state_r      <= ST_EVAL;
                    end else begin
                        flag_ready_r <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_EVAL: begin
                    result_r       <= eval_result_s;
                    flag_err_r     <= eval_err_s;
                    result_valid_r <= 1'b1;
                    state_r        <= ST_OUT;
                end
                ST_OUT: begin
                    if (result_ready) begin
                        result_valid_r <= 1'b0;
                        flag_ready_r   <= 1'b1;
                        state_r        <= ST_IDLE;
                    end else begin
                        result_valid_r <= 1'b1;
                        state_r        <= ST_OUT;
                    end
                end
                default: begin
                    result_valid_r <= 1'b0;
                    flag_ready_r   <= 1'b1;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of accepted flag sets carrying V=1; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            ovf_count_r <= {CNT_W{1'b0}};
        end else if (accept_s && v_in && (ovf_count_r != {CNT_W{1'b1}})) begin
            ovf_count_r <= ovf_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ovf_count_r <= ovf_count_r;
        end
    end

    assign flag_ready   = flag_ready_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign flag_err     = flag_err_r;
    assign ovf_count    = ovf_count_r;

endmodule
